bluetooth_tx: RTL and testbench



---
 rtl/bt_uart_pkg.sv | 34 +++
 rtl/baud_tick_gen.sv | 49 ++++
 rtl/bluetooth_tx.sv | 185 ++++++++++++++++++
 tb/tb_bluetooth_tx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/bt_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bt_uart_pkg
//  Purpose  : Shared types and rate math for the Bluetooth-link UART
//             transmitter and receiver.
//  Contents : tx_state_e      - transmitter FSM states
//             FRAME_DATA_BITS - data bits per frame
//             bit_cycles()    - clocks per bit from clock and baud rate
//  Options  : BLUETOOTH_TX_PARITY_EN adds the TX_PARITY state.
//  Revision : 1.0 - initial release
// ============================================================================
package bt_uart_pkg;

  localparam int unsigned FRAME_DATA_BITS = 8;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
`ifdef BLUETOOTH_TX_PARITY_EN
    TX_PARITY = 3'd3,
`endif
    TX_STOP   = 3'd4
  } tx_state_e;

  // Integer division: the per-bit error is absorbed by the receiver's
  // mid-bit sampling.
  function automatic int unsigned bit_cycles(input int unsigned clk_freq,
                                             input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/baud_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : baud_tick_gen
//  Purpose  : Bit-period timer. Emits a one-clock tick every BIT_CYCLES
//             clocks, counted from the last synchronous clear.
//  Ports    : clk    - system clock
//             rst    - synchronous active-low reset
//             clr_i  - synchronous clear, restarts the bit period
//             tick_o - high on the last clock of each bit period
//  Params   : BIT_CYCLES - clocks per bit (>= 2)
//  Revision : 1.0 - initial release
// ============================================================================
module baud_tick_gen #(
  parameter int unsigned BIT_CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          w_last;

  assign w_last = (cnt_q == CW'(BIT_CYCLES - 1));

  // Tick depends on the counter only, so a caller may derive clr_i from
  // tick_o without forming a combinational loop.
  assign tick_o = w_last;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || w_last) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bluetooth_tx.sv
`default_nettype none
// ============================================================================
//  Module   : bluetooth_tx
//  Purpose  : UART transmitter for the Bluetooth module link. One-entry
//             holding register behind a valid/ready handshake, serialised
//             as start bit, 8 data bits LSB first, stop bit.
//  Ports    : clk      - system clock
//             rst      - synchronous active-low reset
//             tx_data  - byte to send, sampled on an accepting edge
//             tx_valid - producer offers tx_data
//             tx_ready - holding register empty
//             TxD      - serial line, idle high
//             busy     - frame in progress or holding register full
//  Params   : CLK_FREQ, BAUD_RATE, BIT_CYCLES (derived, >= 2)
//  Options  : BLUETOOTH_TX_PARITY_EN inserts an even-parity bit before the
//             stop bit (11-bit frame). Undefined: plain 8N1.
//  Revision : 1.0 - initial release
// ============================================================================
module bluetooth_tx
  import bt_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 9_600,
  parameter int unsigned BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD_RATE)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       TxD,
  output logic       busy
);

  tx_state_e  state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       txd_q, txd_d;
`ifdef BLUETOOTH_TX_PARITY_EN
  logic       parity_q, parity_d;
`endif

  logic w_tick;
  logic w_clr;
  logic w_accept;

  baud_tick_gen #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clr_i (w_clr),
    .tick_o(w_tick)
  );

  // Ready comes from the holding flag alone; tx_valid never feeds it.
  assign tx_ready = !hold_full_q;
  assign w_accept = tx_valid && !hold_full_q;
  assign TxD      = txd_q;
  assign busy     = (state_q != TX_IDLE) || hold_full_q;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
`ifdef BLUETOOTH_TX_PARITY_EN
    parity_d    = parity_q;
`endif
    w_clr       = 1'b0;

    case (state_q)
      TX_IDLE: begin
        // Counter parked at zero while idle so START gets a full bit.
        w_clr = 1'b1;
        if (hold_full_q) begin
          shift_d     = hold_q;
`ifdef BLUETOOTH_TX_PARITY_EN
          parity_d    = ^hold_q;
`endif
          hold_full_d = 1'b0;
          state_d     = TX_START;
        end
      end

      TX_START: begin
        if (w_tick) begin
          state_d   = TX_DATA;
          bit_idx_d = 3'd0;
        end
      end

      TX_DATA: begin
        if (w_tick) begin
          if (bit_idx_q == 3'(FRAME_DATA_BITS - 1)) begin
`ifdef BLUETOOTH_TX_PARITY_EN
            state_d = TX_PARITY;
`else
            state_d = TX_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
      end

`ifdef BLUETOOTH_TX_PARITY_EN
      TX_PARITY: begin
        if (w_tick) begin
          state_d = TX_STOP;
        end
      end
`endif

      TX_STOP: begin
        if (w_tick) begin
          if (hold_full_q) begin
            // Back-to-back: next start bit follows the stop bit directly.
            shift_d     = hold_q;
`ifdef BLUETOOTH_TX_PARITY_EN
            parity_d    = ^hold_q;
`endif
            hold_full_d = 1'b0;
            w_clr       = 1'b1;
            state_d     = TX_START;
          end else begin
            state_d = TX_IDLE;
          end
        end
      end

      default: begin
        state_d = TX_IDLE;
      end
    endcase

    // Accept only happens with the holding register empty, so it never
    // collides with the drain above.
    if (w_accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    // Line level registered from the next state: glitch-free TxD that
    // changes on the same edge as the state.
    case (state_d)
      TX_START:  txd_d = 1'b0;
      TX_DATA:   txd_d = shift_d[0];
`ifdef BLUETOOTH_TX_PARITY_EN
      TX_PARITY: txd_d = parity_d;
`endif
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= TX_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      txd_q       <= 1'b1;
`ifdef BLUETOOTH_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      txd_q       <= txd_d;
`ifdef BLUETOOTH_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bluetooth_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bluetooth_tx
//  Purpose  : Self-checking bench for bluetooth_tx at BIT_CYCLES=10.
//             A timeline model (frame start times and bytes) predicts TxD,
//             tx_ready and busy after every clock edge.
//  Options  : BLUETOOTH_TX_PARITY_EN selects the 11-bit frame.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bluetooth_tx;

  localparam int BC = 10;
`ifdef BLUETOOTH_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int SEND_BOUND = 4 * FB * BC;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       TxD;
  logic       busy;

  int checks;
  int failures;
  int cyc;

  // Model: per accepted byte, the accept edge, the frame start edge, the byte.
  int         acc_q[$];
  int         st_q[$];
  logic [7:0] byte_q[$];
  int         last_end;

  bluetooth_tx #(
    .CLK_FREQ (1000),
    .BAUD_RATE(100)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .TxD     (TxD),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic m_txd(input int t);
    logic [7:0] bb;
    int         b;
    for (int i = 0; i < st_q.size(); i++) begin
      if (t >= st_q[i] && t < st_q[i] + FB * BC) begin
        b  = (t - st_q[i]) / BC;
        bb = byte_q[i];
        if (b == 0) return 1'b0;
        if (b <= 8) return bb[b-1];
`ifdef BLUETOOTH_TX_PARITY_EN
        if (b == 9) return ^bb;
`endif
        return 1'b1;
      end
    end
    return 1'b1;
  endfunction

  function automatic logic m_ready(input int t);
    for (int i = 0; i < acc_q.size(); i++) begin
      if (acc_q[i] <= t && t < st_q[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic m_busy(input int t);
    if (!m_ready(t)) return 1'b1;
    for (int i = 0; i < st_q.size(); i++) begin
      if (t >= st_q[i] && t < st_q[i] + FB * BC) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, update the model, then check.
  task automatic step(input logic v, input logic [7:0] d, input logic r,
                      output logic acc);
    logic rdy_before;
    int   s;
    rdy_before = m_ready(cyc);
    tx_valid   = v;
    tx_data    = d;
    rst        = r;
    @(posedge clk);
    cyc++;
    acc = 1'b0;
    if (!r) begin
      acc_q.delete();
      st_q.delete();
      byte_q.delete();
      last_end = 0;
    end else if (v && rdy_before) begin
      s = (cyc + 1 > last_end) ? cyc + 1 : last_end;
      acc_q.push_back(cyc);
      st_q.push_back(s);
      byte_q.push_back(d);
      last_end = s + FB * BC;
      acc = 1'b1;
    end
    #1;
    chk("txd",      TxD,      m_txd(cyc));
    chk("tx_ready", tx_ready, m_ready(cyc));
    chk("busy",     busy,     m_busy(cyc));
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int k = 0; k < n; k++) step(1'b0, 8'($urandom), 1'b1, acc);
  endtask

  // Hold tx_valid until accepted; data is junk on edges where the model
  // says ready is low, so ignored data changes are exercised.
  task automatic send(input logic [7:0] b);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < SEND_BOUND) begin
      if (m_ready(cyc)) step(1'b1, b, 1'b1, acc);
      else              step(1'b1, 8'($urandom), 1'b1, acc);
      n++;
    end
  endtask

  initial begin
    int   st_ff;
    logic acc;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    last_end = 0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    rst      = 1'b0;

    // Reset state, then a quiet idle line.
    for (int k = 0; k < 3; k++) step(1'b1, 8'hC3, 1'b0, acc);
    idle(50);

    // Single byte.
    send(8'h55);
    idle(110);

    // Back-to-back pair with valid held.
    send(8'hA3);
    send(8'h0F);
    idle(2 * FB * BC + 10);

    // Third byte offered while one shifts and one is held.
    send(8'h11);
    send(8'h22);
    send(8'h33);
    idle(3 * FB * BC + 10);

    // Reset in the 4th data bit of 0xFF with a byte held.
    send(8'hFF);
    st_ff = st_q[st_q.size() - 1];
    send(8'h5A);
    while (cyc < st_ff + 4 * BC + 3) idle(1);
    step(1'b0, 8'h99, 1'b0, acc);
    idle(2 * FB * BC);

    // Random bytes with random gaps (gap 0 gives back-to-back frames).
    for (int k = 0; k < 8; k++) begin
      idle($urandom_range(0, 15));
      send(8'($urandom));
    end
    idle(2 * FB * BC + 10);

`ifdef BLUETOOTH_TX_PARITY_EN
    send(8'h07);
    idle(FB * BC + 20);
    send(8'h03);
    idle(FB * BC + 20);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
